// File: rtl/bitsum_sequencer_if.sv
// Bundles the producer push channel and the downstream bitsum unit channel.
// The slave modport is the sequencer's view; the master modport is the view of
// the environment around it (the producer plus the bitsum unit).
interface bitsum_sequencer_if;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic        bs_start;
    logic [31:0] bs_in;
    logic        bs_finish;
    logic [31:0] bs_result;

    modport slave (
        input  push_valid, push_data, bs_finish, bs_result,
        output push_ready, bs_start, bs_in
    );

    modport master (
        output push_valid, push_data, bs_finish, bs_result,
        input  push_ready, bs_start, bs_in
    );
endinterface

// File: rtl/bitsum_sequencer.sv
// bitsum_sequencer: buffers 32-bit words in a small FIFO and feeds them one at
// a time to a downstream bitsum unit through a start/finish level handshake.
// Accepted results are added into a saturating running total.
// Optional feature: define BITSUM_SEQ_TIMEOUT_EN to abandon a word after
// TIMEOUT RUN cycles without a finish and raise the sticky err flag.
module bitsum_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    bitsum_sequencer_if.slave   bus,
    input  logic                clr,
    output logic [31:0]         total,
    output logic                total_valid,
    output logic [7:0]          words_done,
    output logic                busy,
    output logic                err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bitsum_sequencer: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("bitsum_sequencer: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DROP
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_bs_in;
    logic          r_first;
    logic [31:0]   r_total;
    logic          r_total_valid;
    logic [7:0]    r_words_done;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_start;
    logic          w_acc;
    logic          w_tmo;
    logic [32:0]   w_sum;
    logic [31:0]   w_sat;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.push_valid && !w_full;

    assign w_sum = {1'b0, r_total} + {1'b0, bus.bs_result};
    assign w_sat = w_sum[32] ? '1 : w_sum[31:0];

    assign bus.push_ready = !w_full;
    assign bus.bs_start   = w_start;
    assign bus.bs_in      = r_bs_in;
    assign total          = r_total;
    assign total_valid    = r_total_valid;
    assign words_done     = r_words_done;
    assign busy           = (r_state != S_IDLE) || !w_empty;

    // FIFO storage; contents need no reset because occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.push_data;
        end
    end

    // FIFO pointers and occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state, pop strobe, start level and finish acceptance
    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_start = 1'b0;
        w_acc   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop  = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                w_start = 1'b1;
                // a finish already high on the first RUN cycle belongs to an older word
                w_acc   = bus.bs_finish && !r_first;
                if (w_acc || w_tmo) begin
                    w_next = S_DROP;
                end
            end
            S_DROP: begin
                if (!bus.bs_finish) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Word latch for the bitsum unit and first-RUN-cycle marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bs_in <= '0;
            r_first <= 1'b0;
        end else begin
            if (w_pop) begin
                r_bs_in <= r_mem[r_rd_ptr];
            end
            r_first <= (r_state == S_LOAD);
        end
    end

    // Saturating accumulate; clr coinciding with an accumulate restarts from the new result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total       <= '0;
            r_words_done  <= '0;
            r_total_valid <= 1'b0;
        end else begin
            r_total_valid <= w_acc;
            if (w_acc) begin
                if (clr) begin
                    r_total      <= bus.bs_result;
                    r_words_done <= 8'd1;
                end else begin
                    r_total      <= w_sat;
                    r_words_done <= r_words_done + 8'd1;
                end
            end else if (clr) begin
                r_total      <= '0;
                r_words_done <= '0;
            end
        end
    end

`ifdef BITSUM_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;

    assign w_tmo = (r_state == S_RUN) && (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign err   = r_err;

    // RUN cycle counter; restarts whenever the FSM leaves RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Sticky timeout flag, raised only when the word is abandoned without a finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_tmo && !w_acc) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_bitsum_sequencer.sv
// Testbench for bitsum_sequencer: a behavioural bitsum unit model, directed
// stimulus and a scoreboard drained by a monitor on total_valid.
module tb_bitsum_sequencer;

    localparam int unsigned TB_DEPTH   = 4;
    localparam int unsigned TB_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] total;
    logic        total_valid;
    logic [7:0]  words_done;
    logic        busy;
    logic        err;

    bitsum_sequencer_if bif ();

    bitsum_sequencer #(
        .DEPTH  (TB_DEPTH),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .clr        (clr),
        .total      (total),
        .total_valid(total_valid),
        .words_done (words_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Bitsum unit model: finish rises on the 4th cycle of start (three edges after
    // start), drops with start; stall suppresses it, sticky forces it high.
    logic [15:0] mcnt   = '0;
    logic        stall  = 1'b0;
    logic        sticky = 1'b0;
    logic        raw    = 1'b0;

    always @(posedge clk) mcnt <= bif.bs_start ? mcnt + 16'd1 : 16'd0;

    assign bif.bs_finish = sticky | (bif.bs_start & ~stall & (mcnt >= 16'd3));
    assign bif.bs_result = raw ? bif.bs_in : 32'($countones(bif.bs_in));

    typedef struct packed {
        logic [31:0] tot;
        logic [7:0]  wd;
    } exp_t;

    exp_t sbq[$];
    int   n_chk   = 0;
    int   n_bad   = 0;
    int   n_pulse = 0;
    int   run_cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per total_valid pulse
    always @(negedge clk) begin
        if (bif.bs_start === 1'b1) run_cyc++;
        if (total_valid === 1'b1) begin
            exp_t e;
            n_pulse++;
            if (sbq.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL sb_unexpected: got total=%h words=%0d want no pulse", total, words_done);
            end else begin
                e = sbq.pop_front();
                check("sb_total", total, e.tot);
                check("sb_words", 32'(words_done), 32'(e.wd));
            end
        end
    end

    task automatic expect_result(input logic [31:0] t, input logic [7:0] w);
        exp_t e;
        e.tot = t;
        e.wd  = w;
        sbq.push_back(e);
    endtask

    task automatic push(input logic [31:0] w, input string nm);
        int n = 0;
        @(negedge clk);
        while (bif.push_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready"}, 32'(bif.push_ready), 32'd1);
        bif.push_valid = 1'b1;
        bif.push_data  = w;
        @(posedge clk);
        #1;
        bif.push_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_start(input string nm, input int max);
        int n = 0;
        @(negedge clk);
        while (bif.bs_start !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_start"}, 32'(bif.bs_start), 32'd1);
    endtask

    task automatic clear_idle();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_bs_start"}, 32'(bif.bs_start), 32'd0);
        check({nm, "_bs_in"}, bif.bs_in, 32'd0);
        check({nm, "_total"}, total, 32'd0);
        check({nm, "_total_valid"}, 32'(total_valid), 32'd0);
        check({nm, "_words"}, 32'(words_done), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_err"}, 32'(err), 32'd0);
        check({nm, "_push_ready"}, 32'(bif.push_ready), 32'd1);
    endtask

    // Hand-computed running totals for words 1..5 through a DEPTH=4 FIFO
    logic [31:0] fill_tot [5] = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15};

    initial begin
        int p0;
        bif.push_valid = 1'b0;
        bif.push_data  = '0;

        // reset values
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // three words of eight set bits each
        p0 = n_pulse;
        expect_result(32'd8, 8'd1);
        push(32'h0000_00FF, "b8a");
        expect_result(32'd16, 8'd2);
        push(32'h0000_FF00, "b8b");
        expect_result(32'd24, 8'd3);
        push(32'hF0F0_0000, "b8c");
        wait_idle("b8", 200);
        check("b8_total", total, 32'd24);
        check("b8_words", 32'(words_done), 32'd3);
        check("b8_pulses", 32'(n_pulse - p0), 32'd3);

        // clr in the accumulate cycle, result 5
        expect_result(32'd5, 8'd1);
        push(32'h0000_001F, "clracc");
        begin
            int n = 0;
            @(negedge clk);
            while (!(bif.bs_start === 1'b1 && bif.bs_finish === 1'b1) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("clracc_fin", 32'(bif.bs_finish), 32'd1);
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
        end
        wait_idle("clracc", 100);

        // clr while idle
        clear_idle();
        @(negedge clk);
        check("clr_total", total, 32'd0);
        check("clr_words", 32'(words_done), 32'd0);

        // saturation
        raw = 1'b1;
        expect_result(32'hFFFF_FFF0, 8'd1);
        push(32'hFFFF_FFF0, "sat0");
        expect_result(32'hFFFF_FFFF, 8'd2);
        push(32'h0000_0020, "sat1");
        expect_result(32'hFFFF_FFFF, 8'd3);
        push(32'h0000_0020, "sat2");
        wait_idle("sat", 200);
        check("sat_total", total, 32'hFFFF_FFFF);

        // finish already high before start: accepted on the 2nd RUN cycle only
        clear_idle();
        sticky  = 1'b1;
        p0      = n_pulse;
        run_cyc = 0;
        expect_result(32'd7, 8'd1);
        push(32'h0000_0007, "stale");
        repeat (8) @(negedge clk);
        sticky = 1'b0;
        wait_idle("stale", 100);
        check("stale_run_cycles", 32'(run_cyc), 32'd2);
        check("stale_pulses", 32'(n_pulse - p0), 32'd1);

        // fill while the unit stalls: one word sits in the unit, DEPTH fill the FIFO
        clear_idle();
        stall = 1'b1;
        expect_result(fill_tot[0], 8'd1);
        push(32'd1, "fill1");
        wait_start("fill", 50);
        for (int i = 2; i <= 5; i++) begin
            expect_result(fill_tot[i-1], 8'(i));
            push(32'(i), "fill");
        end
        @(negedge clk);
        check("full_ready", 32'(bif.push_ready), 32'd0);
        bif.push_valid = 1'b1;
        bif.push_data  = 32'h0000_1000;
        @(posedge clk);
        #1;
        bif.push_valid = 1'b0;
`ifndef BITSUM_SEQ_TIMEOUT_EN
        repeat (300) @(negedge clk);
        check("stall_err", 32'(err), 32'd0);
        check("stall_words", 32'(words_done), 32'd0);
`endif
        stall = 1'b0;
        wait_idle("fill", 300);
        check("fill_total", total, 32'd15);
        check("fill_words", 32'(words_done), 32'd5);

`ifdef BITSUM_SEQ_TIMEOUT_EN
        // unit never finishes: abandoned after TIMEOUT RUN cycles, no accumulate
        clear_idle();
        stall   = 1'b1;
        run_cyc = 0;
        push(32'd9, "tmo");
        begin
            int n = 0;
            @(negedge clk);
            while (err !== 1'b1 && n < 600) begin
                @(negedge clk);
                n++;
            end
        end
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_run_cycles", 32'(run_cyc), 32'(TB_TIMEOUT));
        check("tmo_total", total, 32'd0);
        check("tmo_words", 32'(words_done), 32'd0);
        stall = 1'b0;
        expect_result(32'd3, 8'd1);
        push(32'd3, "tmo_next");
        wait_idle("tmo_next", 100);
        check("tmo_err_sticky", 32'(err), 32'd1);
`endif

        // reset in the middle of RUN with a word still queued
        stall = 1'b1;
        push(32'h0000_0011, "mid");
        wait_start("mid", 50);
        push(32'h0000_0022, "mid2");
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_words", 32'(words_done), 32'd0);
        check("post_rst_total", total, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got no completion want completion within 50000 cycles");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
